// File: rtl/icache_intc_pkg.sv
// rtl/icache_intc_pkg.sv - shared types for the icache interconnect request arbiter
package icache_intc_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/icache_intc_id_fifo.sv
// rtl/icache_intc_id_fifo.sv - in-order FIFO of granted requester indices
module icache_intc_id_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);

    // Storage needs no reset: the occupancy counter decides what is valid.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally; occupancy is tracked separately so full and empty are unambiguous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/icache_intc_req_arb.sv
// rtl/icache_intc_req_arb.sv - round-robin request arbiter with in-order response routing
module icache_intc_req_arb
    import icache_intc_pkg::*;
#(
    parameter int N_REQ           = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            request_i,
    input  logic [N_REQ*ADDR_WIDTH-1:0] add_i,
    output logic [N_REQ-1:0]            grant_o,
    output logic                        request_o,
    output logic [ADDR_WIDTH-1:0]       add_o,
    input  logic                        grant_i,
    input  logic                        response_i,
    input  logic [DATA_WIDTH-1:0]       read_data_i,
    output logic [N_REQ-1:0]            response_o,
    output logic [DATA_WIDTH-1:0]       read_data_o,
    output logic                        error_o
);

    localparam int IDX_W = $clog2(N_REQ);

    arb_state_e       state_q;
    logic [IDX_W-1:0] lock_idx_q;
    logic [IDX_W-1:0] rr_ptr_q;
    logic             error_q;

    logic [IDX_W-1:0] scan_idx;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_valid;
    logic [IDX_W-1:0] sel;
    logic             cand;
    logic             handshake;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [IDX_W-1:0] fifo_head;

    // Round-robin scan from rr_ptr upward; descending offsets so the nearest requester wins.
    always_comb begin
        arb_valid = 1'b0;
        arb_idx   = '0;
        scan_idx  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            scan_idx = rr_ptr_q + k[IDX_W-1:0];
            if (request_i[scan_idx]) begin
                arb_valid = 1'b1;
                arb_idx   = scan_idx;
            end
        end
    end

    // While locked, the selection is frozen on the requester that saw a stalled request.
    assign sel       = (state_q == LOCK) ? lock_idx_q : arb_idx;
    assign cand      = (state_q == LOCK) ? request_i[lock_idx_q] : arb_valid;
    assign request_o = rst_n & cand & ~fifo_full;
    assign handshake = request_o & grant_i;
    assign add_o     = request_o ? add_i[sel*ADDR_WIDTH +: ADDR_WIDTH] : '0;

    assign fifo_pop    = rst_n & response_i & ~fifo_empty;
    assign read_data_o = rst_n ? read_data_i : '0;
    assign error_o     = error_q;

    // One-hot grant back to the selected requester and one-hot response to the oldest grantee.
    always_comb begin
        grant_o              = '0;
        grant_o[sel]         = handshake;
        response_o           = '0;
        response_o[fifo_head] = fifo_pop;
    end

    // Arbitration FSM, round-robin pointer and sticky protocol error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB;
            lock_idx_q <= '0;
            rr_ptr_q   <= '0;
            error_q    <= 1'b0;
        end else begin
            case (state_q)
                ARB: begin
                    if (request_o && !grant_i) begin
                        state_q    <= LOCK;
                        lock_idx_q <= sel;
                    end
                end
                LOCK: begin
                    if (handshake) begin
                        state_q <= ARB;
                    end else if (!request_i[lock_idx_q]) begin
                        state_q <= ARB;
                        error_q <= 1'b1;
                    end
                end
                default: state_q <= ARB;
            endcase
            if (handshake) begin
                rr_ptr_q <= sel + IDX_W'(1);
            end
            if (response_i && fifo_empty) begin
                error_q <= 1'b1;
            end
        end
    end

    icache_intc_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDX_W)
    ) u_id_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (handshake),
        .pop_i   (fifo_pop),
        .data_i  (sel),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_icache_intc_req_arb.sv
// tb/tb_icache_intc_req_arb.sv - randomized and directed bench for icache_intc_req_arb
module tb_icache_intc_req_arb;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    request_i = '0;
    logic [N*AW-1:0] add_i = '0;
    logic [N-1:0]    grant_o;
    logic            request_o;
    logic [AW-1:0]   add_o;
    logic            grant_i = 1'b0;
    logic            response_i = 1'b0;
    logic [DW-1:0]   read_data_i = '0;
    logic [N-1:0]    response_o;
    logic [DW-1:0]   read_data_o;
    logic            error_o;

    int n_checks = 0;
    int n_fail   = 0;

    bit m_locked;
    int m_lock_idx;
    int m_rr;
    int m_q[$];
    bit m_err;

    icache_intc_req_arb #(
        .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .request_i(request_i), .add_i(add_i),
        .grant_o(grant_o), .request_o(request_o), .add_o(add_o), .grant_i(grant_i),
        .response_i(response_i), .read_data_i(read_data_i), .response_o(response_o),
        .read_data_o(read_data_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked   = 1'b0;
        m_lock_idx = 0;
        m_rr       = 0;
        m_q.delete();
        m_err      = 1'b0;
    endtask

    // Compares the current outputs against the rules, then advances the model past the next edge.
    task automatic compare_and_step();
        int           sel;
        bit           cand;
        bit           req;
        bit           hs;
        logic [N-1:0] eg;
        logic [N-1:0] er;
        logic [AW-1:0] ea;
        sel  = 0;
        cand = 1'b0;
        eg   = '0;
        er   = '0;
        ea   = '0;
        if (!rst_n) begin
            check("rst_grant", 64'(grant_o), 64'(0));
            check("rst_req", 64'(request_o), 64'(0));
            check("rst_add", 64'(add_o), 64'(0));
            check("rst_resp", 64'(response_o), 64'(0));
            check("rst_rdata", 64'(read_data_o), 64'(0));
            check("rst_err", 64'(error_o), 64'(0));
            model_reset();
            return;
        end
        if (m_locked) begin
            sel  = m_lock_idx;
            cand = request_i[sel];
        end else begin
            for (int k = 0; k < N; k++) begin
                if (request_i[(m_rr + k) % N]) begin
                    sel  = (m_rr + k) % N;
                    cand = 1'b1;
                    break;
                end
            end
        end
        req = cand && (m_q.size() < MO);
        hs  = req && grant_i;
        if (hs) eg[sel] = 1'b1;
        if (req) ea = add_i[sel*AW +: AW];
        if (response_i && m_q.size() > 0) er[m_q[0]] = 1'b1;
        check("grant", 64'(grant_o), 64'(eg));
        check("req", 64'(request_o), 64'(req));
        check("add", 64'(add_o), 64'(ea));
        check("resp", 64'(response_o), 64'(er));
        check("rdata", 64'(read_data_o), 64'(read_data_i));
        check("err", 64'(error_o), 64'(m_err));
        if (response_i) begin
            if (m_q.size() > 0) void'(m_q.pop_front());
            else m_err = 1'b1;
        end
        if (hs) begin
            m_q.push_back(sel);
            m_rr     = (sel + 1) % N;
            m_locked = 1'b0;
        end else if (m_locked && !request_i[m_lock_idx]) begin
            m_err    = 1'b1;
            m_locked = 1'b0;
        end else if (!m_locked && req) begin
            m_locked   = 1'b1;
            m_lock_idx = sel;
        end
    endtask

    task automatic cycle(input logic r, input logic [N-1:0] req, input logic g,
                         input logic resp, input logic [DW-1:0] rd);
        @(negedge clk);
        rst_n       = r;
        request_i   = req;
        grant_i     = g;
        response_i  = resp;
        read_data_i = rd;
        for (int k = 0; k < N; k++) add_i[k*AW +: AW] = $urandom;
        #1;
        compare_and_step();
    endtask

    task automatic do_reset();
        cycle(1'b0, '0, 1'b0, 1'b0, '0);
        cycle(1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    logic [N-1:0] seq034 [5];
    logic [N-1:0] seq037 [3];
    logic [N-1:0] rq;

    initial begin
        seq034 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        seq037 = '{4'b0100, 4'b0001, 4'b1000};
        model_reset();
        do_reset();

        // Full-load rotation; responses keep the FIFO from filling.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 4'b1111, 1'b1, i > 0, $urandom);
            check("rr_seq", 64'(grant_o), 64'(seq034[i]));
        end
        do_reset();

        // Lock held through a stall, then the locked requester wins despite a lower one appearing.
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'b0100, 1'b0, 1'b0, '0);
        cycle(1'b1, 4'b0101, 1'b1, 1'b0, '0);
        check("lock_grant", 64'(grant_o), 64'(4'b0100));
        cycle(1'b1, 4'b1111, 1'b1, 1'b0, '0);
        check("rr_after_lock", 64'(grant_o), 64'(4'b1000));
        do_reset();

        // Fill the FIFO from requester 1, then free one slot.
        for (int i = 0; i < 4; i++) cycle(1'b1, 4'b0010, 1'b1, 1'b0, '0);
        cycle(1'b1, 4'b0010, 1'b1, 1'b0, '0);
        check("full_block", 64'(request_o), 64'(0));
        cycle(1'b1, 4'b0010, 1'b1, 1'b1, 32'hDEADBEEF);
        check("full_resp", 64'(response_o), 64'(4'b0010));
        check("full_rdata", 64'(read_data_o), 64'(32'hDEADBEEF));
        check("full_no_bypass", 64'(request_o), 64'(0));
        cycle(1'b1, 4'b0010, 1'b1, 1'b0, '0);
        check("full_reassert", 64'(request_o), 64'(1));
        do_reset();

        // In-order response routing.
        cycle(1'b1, 4'b0100, 1'b1, 1'b0, '0);
        cycle(1'b1, 4'b0001, 1'b1, 1'b0, '0);
        cycle(1'b1, 4'b1000, 1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 4'b0000, 1'b0, 1'b1, $urandom);
            check("resp_order", 64'(response_o), 64'(seq037[i]));
        end
        do_reset();

        // Stray response sets the sticky error.
        cycle(1'b1, 4'b0000, 1'b0, 1'b1, '0);
        check("stray_resp", 64'(response_o), 64'(0));
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 4'b0000, 1'b0, 1'b0, '0);
            check("err_sticky", 64'(error_o), 64'(1));
        end
        do_reset();
        check("err_cleared", 64'(error_o), 64'(0));

        // Mid-cycle reset discards outstanding IDs and the round-robin pointer.
        cycle(1'b1, 4'b1111, 1'b1, 1'b0, '0);
        cycle(1'b1, 4'b1111, 1'b1, 1'b0, '0);
        @(posedge clk);
        #2;
        response_i = 1'b1;
        rst_n      = 1'b0;
        #1;
        check("async_grant", 64'(grant_o), 64'(0));
        check("async_req", 64'(request_o), 64'(0));
        check("async_resp", 64'(response_o), 64'(0));
        check("async_add", 64'(add_o), 64'(0));
        model_reset();
        cycle(1'b0, 4'b1111, 1'b1, 1'b1, '0);
        cycle(1'b1, 4'b1111, 1'b1, 1'b1, '0);
        check("post_rst_grant", 64'(grant_o), 64'(4'b0001));
        check("post_rst_resp", 64'(response_o), 64'(0));
        cycle(1'b1, 4'b0000, 1'b0, 1'b0, '0);
        check("post_rst_err", 64'(error_o), 64'(1));
        do_reset();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rq = 4'($urandom);
            if (m_locked && ($urandom_range(0, 19) != 0)) rq[m_lock_idx] = 1'b1;
            cycle(($urandom_range(0, 149) != 0), rq, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 9) < 3, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
